// File: rtl/marc_sequencer.sv
// marc_sequencer: phase-by-phase control-word sequencer for the mARC datapath.
// Optional single-step mode under MARC_SEQ_STEP_EN adds a step input.
module marc_sequencer #(
  parameter int DATA_W = 16,
  parameter int CW_W = 20,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] instruction,
  input  logic              mem_ready,
  input  logic              halt,
`ifdef MARC_SEQ_STEP_EN
  input  logic              step,
`endif
  output logic [CW_W-1:0]   ctrlword,
  output logic [2:0]        phase,
  output logic              illegal,
  output logic [CNT_W-1:0]  instr_count
);
  typedef enum logic [2:0] {S_RST, S_IF, S_ID, S_OF, S_EX, S_IP, S_HALT, S_TRAP} state_t;
  localparam logic [4:0] OP_NOP = 5'b00000, OP_SETLOW = 5'b01010, OP_SETHI = 5'b01011;
  localparam logic [CW_W-1:0] W_IF = CW_W'(20'b11100000111111000000);
  localparam logic [CW_W-1:0] W_OF_LO = CW_W'(20'b11111001110110000000);
  localparam logic [CW_W-1:0] W_EX_LO = CW_W'(20'b11011101000110000000);
  localparam logic [CW_W-1:0] W_OF_HI = CW_W'(20'b10101011110110000000);
  localparam logic [CW_W-1:0] W_EX_HI = CW_W'(20'b11111101001010001101);
  localparam logic [CW_W-1:0] W_IP = CW_W'(20'b11101100111010000100);
  state_t state, next;
  logic [4:0] opcode, op_in, op_next;
  logic [CW_W-1:0] word_next;
  logic unused_bits;
  assign op_in = instruction[DATA_W-1 -: 5];
  assign unused_bits = ^instruction[DATA_W-6:0];
  assign phase = state;
  always_comb begin
    op_next = (state == S_ID) ? op_in : opcode;
    next = state;
    case (state)
      S_RST: next = S_IF;
      S_IF: next = mem_ready ? S_ID : S_IF;
      S_ID: next = (op_in == OP_NOP) ? S_IP :
                   (op_in == OP_SETLOW || op_in == OP_SETHI) ? S_OF : S_TRAP;
      S_OF: next = S_EX;
      S_EX: next = S_IP;
`ifdef MARC_SEQ_STEP_EN
      S_IP: next = S_HALT;
      S_HALT: next = (step && !halt) ? S_IF : S_HALT;
`else
      S_IP: next = halt ? S_HALT : S_IF;
      S_HALT: next = halt ? S_HALT : S_IF;
`endif
      default: next = S_TRAP;
    endcase
    // only setlow/sethi reach OF/EX, so opcode bit 0 selects the high variant
    word_next = (next == S_IF) ? W_IF :
                (next == S_OF) ? (op_next[0] ? W_OF_HI : W_OF_LO) :
                (next == S_EX) ? (op_next[0] ? W_EX_HI : W_EX_LO) :
                (next == S_IP) ? W_IP : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_RST;
      opcode <= '0;
      ctrlword <= '0;
      illegal <= 1'b0;
      instr_count <= '0;
    end else begin
      state <= next;
      opcode <= op_next;
      ctrlword <= word_next;
      illegal <= illegal | (next == S_TRAP);
      if (state == S_IP) instr_count <= instr_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_marc_sequencer.sv
// tb_marc_sequencer: randomized instruction-level scoreboard bench for marc_sequencer.
module tb_marc_sequencer;
  localparam int CNT_W = 2;
  localparam logic [4:0] OP_NOP = 5'b00000, OP_SETLOW = 5'b01010, OP_SETHI = 5'b01011;
  logic clk = 1'b0, reset = 1'b1, mem_ready = 1'b0, halt = 1'b0;
  logic [15:0] instruction = '0;
  logic [19:0] ctrlword;
  logic [2:0] phase;
  logic illegal;
  logic [CNT_W-1:0] instr_count;
  always #5 clk = ~clk;
  marc_sequencer #(.DATA_W(16), .CW_W(20), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .mem_ready(mem_ready),
    .halt(halt), .ctrlword(ctrlword), .phase(phase), .illegal(illegal),
    .instr_count(instr_count)
  );
  typedef struct packed {
    logic [2:0] ph;
    logic [19:0] cw;
    logic il;
    logic [CNT_W-1:0] cnt;
  } exp_t;
  exp_t q[$];
  int vectors = 0, miscompares = 0, retired = 0;
  logic trapped = 1'b0;
  logic [4:0] cur_op = '0;
  function automatic logic [19:0] cw_of(input logic [2:0] ph, input logic [4:0] op);
    case (ph)
      3'd1: return 20'b11100000111111000000;
      3'd3: return (op == OP_SETHI) ? 20'b10101011110110000000 : 20'b11111001110110000000;
      3'd4: return (op == OP_SETHI) ? 20'b11111101001010001101 : 20'b11011101000110000000;
      3'd5: return 20'b11101100111010000100;
      default: return 20'b0;
    endcase
  endfunction
  function automatic logic is_load(input logic [4:0] op);
    return op == OP_SETLOW || op == OP_SETHI;
  endfunction
  task automatic cyc(input logic rst, input logic mr, input logic [15:0] ins, input logic h,
                     input logic [2:0] exp_ph);
    @(negedge clk);
    reset = rst;
    mem_ready = mr;
    instruction = ins;
    halt = h;
    if (rst) begin
      retired = 0;
      trapped = 1'b0;
    end
    if (exp_ph == 3'd7) trapped = 1'b1;
    q.push_back('{ph: exp_ph, cw: cw_of(exp_ph, cur_op), il: trapped, cnt: CNT_W'(retired)});
  endtask
  function automatic logic [15:0] junk();
    return 16'($urandom);
  endfunction
  function automatic logic rbit();
    return 1'($urandom);
  endfunction
  task automatic do_reset(input int n);
    repeat (n) cyc(1'b1, rbit(), junk(), rbit(), 3'd0);
    cyc(1'b0, rbit(), junk(), rbit(), 3'd1);
  endtask
  task automatic run_instr(input logic [4:0] op, input int waits, input int hold);
    repeat (waits) cyc(1'b0, 1'b0, junk(), rbit(), 3'd1);
    cyc(1'b0, 1'b1, junk(), rbit(), 3'd2);
    cur_op = op;
    if (op == OP_NOP) cyc(1'b0, rbit(), {op, 11'($urandom)}, rbit(), 3'd5);
    else if (is_load(op)) begin
      cyc(1'b0, rbit(), {op, 11'($urandom)}, rbit(), 3'd3);
      cyc(1'b0, rbit(), junk(), rbit(), 3'd4);
      cyc(1'b0, rbit(), junk(), rbit(), 3'd5);
    end else begin
      cyc(1'b0, rbit(), {op, 11'($urandom)}, rbit(), 3'd7);
      repeat (10) cyc(1'b0, rbit(), junk(), rbit(), 3'd7);
      return;
    end
    retired++;
    repeat (hold) cyc(1'b0, rbit(), junk(), 1'b1, 3'd6);
    cyc(1'b0, rbit(), junk(), 1'b0, 3'd1);
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        vectors++;
        if ({phase, ctrlword, illegal, instr_count} !== e) begin
          miscompares++;
          $display("FAIL vec %0d: got phase=%0d cw=%b illegal=%b count=%0d, want phase=%0d cw=%b illegal=%b count=%0d",
                   vectors, phase, ctrlword, illegal, instr_count, e.ph, e.cw, e.il, e.cnt);
        end
      end
    end
  end
  initial begin : stimulus
    logic [4:0] op;
    do_reset(2);
    run_instr(OP_SETLOW, 0, 0);
    run_instr(OP_SETHI, 0, 0);
    run_instr(OP_NOP, 0, 0);
    run_instr(OP_NOP, 4, 0);
    run_instr(OP_NOP, 0, 3);
    repeat (5) run_instr(OP_NOP, 0, 0);
    run_instr(5'b11111, 0, 0);
    do_reset(1);
    cyc(1'b0, 1'b1, junk(), 1'b0, 3'd2);
    cur_op = OP_SETLOW;
    cyc(1'b0, 1'b0, {OP_SETLOW, 11'd5}, 1'b0, 3'd3);
    cyc(1'b0, 1'b0, junk(), 1'b0, 3'd4);
    do_reset(1);
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 7))
        0: op = 5'($urandom);
        1, 2: op = OP_NOP;
        3, 4, 5: op = OP_SETLOW;
        default: op = OP_SETHI;
      endcase
      run_instr(op, $urandom_range(0, 3), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
      if (op != OP_NOP && !is_load(op)) do_reset($urandom_range(1, 2));
    end
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/marc_sequencer.md
Name: marc_sequencer

Overview:
- Parametrised control sequencer for the mARC datapath. It generates the 20-bit control word phase by phase, which the bench currently drives by hand.
- Fetches instructions with a ready handshake, decodes opcode fields from the datapath's instruction output and walks the IF/ID/OF/EX/IP phases.
- Counts retired instructions and traps illegal opcodes.
- Sits beside the datapath: ctrlword out, instruction in.

Parameters:
- DATA_W, 16, instruction width; opcode is always bits [DATA_W-1 : DATA_W-5].
- CW_W, 20, control word width; micro-words below are zero-extended to CW_W.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- instruction  in  DATA_W  current instruction register value from the datapath
- mem_ready  in  1  fetch memory has valid data this cycle
- halt  in  1  request to stop at the next instruction boundary
- ctrlword  out  CW_W  registered control word to the datapath
- phase  out  3  current state: 0 RST, 1 IF, 2 ID, 3 OF, 4 EX, 5 IP, 6 HALT, 7 TRAP
- illegal  out  1  sticky illegal-opcode flag
- instr_count  out  CNT_W  number of instructions retired

Behaviour:
- One clock, clk. reset is synchronous and active-high. All outputs are registered.
- Reset values: phase=RST, ctrlword=0 (ID/idle word), illegal=0, instr_count=0.
- Reset wins over every other input in the same cycle, including mid-fetch, mid-execute and TRAP.
- Micro-words (binary, CW_W=20):
  - IF = 11100000111111000000
  - ID = 0
  - OF_SETLOW = 11111001110110000000
  - EX_SETLOW = 11011101000110000000
  - OF_SETHI = 10101011110110000000
  - EX_SETHI = 11111101001010001101
  - IP = 11101100111010000100
- Opcodes in bits [15:11]: 00000 nop, 01010 setlow, 01011 sethi. Any other value is illegal.
- ctrlword always equals the micro-word of the current phase. It updates on the same edge as phase.
- RST -> IF on the first clock after reset deasserts.
- IF:
  - Outputs IF. Stays in IF while mem_ready=0.
  - When mem_ready=1, moves to ID on the next edge.
- ID:
  - Outputs ID and samples instruction[15:11] into an internal opcode register (1 cycle).
  - nop -> IP (skips OF and EX).
  - setlow or sethi -> OF.
  - Illegal -> TRAP; illegal is set on entry.
- OF: outputs OF_SETLOW or OF_SETHI according to the latched opcode; 1 cycle, then EX.
- EX: outputs EX_SETLOW or EX_SETHI; 1 cycle, then IP.
- IP:
  - Outputs IP and increments instr_count by 1, wrapping modulo 2^CNT_W.
  - Next state is HALT if halt=1 during IP, otherwise IF.
- HALT: outputs ID (0). Returns to IF in the cycle after halt drops to 0.
- TRAP: outputs ID (0). Held until reset; illegal stays 1 and instr_count is frozen.
- halt is sampled only in IP. Asserting it in any other state does not stall the current instruction.
- Latency: setlow/sethi take 5 cycles IF->IP with mem_ready already high; nop takes 3.
- instruction changes outside ID have no effect on the decode.

Optional Feature:
- Macro MARC_SEQ_STEP_EN.
- When defined:
  - Adds input port step (1 bit).
  - IP always goes to HALT, and HALT goes to IF only on a cycle with step=1 (a single-cycle pulse executes exactly one instruction).
  - halt still holds the sequencer in HALT even when step=1; halt wins.
- When undefined: no step port; free-running behaviour as above.

Test Plan:
- setlow decode: reset 2 cycles, mem_ready=1, instruction=0101000101000000 -> ctrlword sequence IF, 0, 11111001110110000000, 11011101000110000000, 11101100111010000100; instr_count=1 after IP.
- sethi then nop: instruction 0101101000000001 then 0000000000000000 -> sethi uses OF_SETHI/EX_SETHI (…001101); nop goes ID->IP directly; instr_count=2 after 8 cycles.
- Fetch wait: mem_ready=0 for 4 cycles in IF -> ctrlword held at IF, phase=1 for all 4 cycles; ID entered on the edge after mem_ready=1.
- Illegal opcode: instruction=1111100000000000 -> phase=7, illegal=1, ctrlword=0, instr_count unchanged; held 10 cycles; reset clears to phase=0, illegal=0.
- Halt and reset mid-op: halt=1 during IP -> phase=6 until halt=0, then IF. Separately, reset asserted in EX -> next cycle phase=0, ctrlword=0, instr_count=0.
- Counter wrap (CNT_W=2): execute 5 nops -> instr_count goes 1, 2, 3, 0, 1.
